// File: rtl/refresh_cmd_mux.sv
// refresh_cmd_mux: merges refresher and bank-machine command streams onto one registered DRAM command bus
module refresh_cmd_mux #(
    parameter int AW  = 17,
    parameter int BAW = 3,
    parameter int GW  = 8
) (
    input  logic           sys_clk,
    input  logic           sys_rst_n,
    input  logic [GW-1:0]  ref_guard_cfg,
    input  logic           ref_cmd_valid,
    output logic           ref_cmd_ready,
    input  logic           ref_cmd_last,
    input  logic [AW-1:0]  ref_cmd_a,
    input  logic [BAW-1:0] ref_cmd_ba,
    input  logic           ref_cmd_cas,
    input  logic           ref_cmd_ras,
    input  logic           ref_cmd_we,
    input  logic           bm_cmd_valid,
    output logic           bm_cmd_ready,
    input  logic [AW-1:0]  bm_cmd_a,
    input  logic [BAW-1:0] bm_cmd_ba,
    input  logic           bm_cmd_cas,
    input  logic           bm_cmd_ras,
    input  logic           bm_cmd_we,
    output logic           out_cmd_valid,
    output logic [AW-1:0]  out_cmd_a,
    output logic [BAW-1:0] out_cmd_ba,
    output logic           out_cmd_cas,
    output logic           out_cmd_ras,
    output logic           out_cmd_we,
    output logic           out_cmd_src,
    output logic           ref_active,
    output logic [15:0]    ref_count,
    output logic           ref_proto_err
);
    typedef enum logic [1:0] {NORMAL, DRAIN, REFRESH} state_t;

    state_t        state, state_nxt;
    logic [GW-1:0] guard;
    logic          bm_hs, ref_issue, ref_done, ref_abort;

    // state register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= NORMAL;
        else            state <= state_nxt;
    end

    // handshakes, grants and next state; refresh always wins over a same-cycle bank request
    always_comb begin
        state_nxt     = state;
        bm_cmd_ready  = sys_rst_n && state == NORMAL && !ref_cmd_valid;
        ref_cmd_ready = state == REFRESH;
        ref_active    = state != NORMAL;
        bm_hs         = bm_cmd_valid && bm_cmd_ready;
        ref_issue     = ref_cmd_ready && ref_cmd_valid && (ref_cmd_ras || ref_cmd_cas || ref_cmd_we);
        ref_done      = ref_cmd_ready && ref_cmd_valid && ref_cmd_last;
        ref_abort     = ref_cmd_ready && !ref_cmd_valid;
        case (state)
            NORMAL:  state_nxt = ref_cmd_valid ? DRAIN : NORMAL;
            DRAIN:   state_nxt = !ref_cmd_valid ? NORMAL : (guard == '0 ? REFRESH : DRAIN);
            REFRESH: state_nxt = (ref_abort || ref_done) ? NORMAL : REFRESH;
            default: state_nxt = NORMAL;
        endcase
    end

    // guard time since the last issued bank command, saturating at zero
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)        guard <= '0;
        else if (bm_hs)        guard <= ref_guard_cfg;
        else if (guard != '0)  guard <= guard - 1'b1;
    end

    // registered command bus; payload holds when nothing is issued
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            out_cmd_valid <= 1'b0;
            out_cmd_a     <= '0;
            out_cmd_ba    <= '0;
            out_cmd_cas   <= 1'b0;
            out_cmd_ras   <= 1'b0;
            out_cmd_we    <= 1'b0;
            out_cmd_src   <= 1'b0;
        end else begin
            out_cmd_valid <= bm_hs || ref_issue;
            if (bm_hs) begin
                out_cmd_a   <= bm_cmd_a;
                out_cmd_ba  <= bm_cmd_ba;
                out_cmd_cas <= bm_cmd_cas;
                out_cmd_ras <= bm_cmd_ras;
                out_cmd_we  <= bm_cmd_we;
                out_cmd_src <= 1'b0;
            end else if (ref_issue) begin
                out_cmd_a   <= ref_cmd_a;
                out_cmd_ba  <= ref_cmd_ba;
                out_cmd_cas <= ref_cmd_cas;
                out_cmd_ras <= ref_cmd_ras;
                out_cmd_we  <= ref_cmd_we;
                out_cmd_src <= 1'b1;
            end
        end
    end

    // completed-sequence counter and sticky protocol error
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ref_count     <= '0;
            ref_proto_err <= 1'b0;
        end else begin
            if (ref_done)  ref_count     <= ref_count + 16'd1;
            if (ref_abort) ref_proto_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_refresh_cmd_mux.sv
// tb_refresh_cmd_mux: randomized scenario bench for refresh_cmd_mux against a timing/scoreboard model
module tb_refresh_cmd_mux;
    localparam int AW = 17, BAW = 3, GW = 8;

    logic           clk = 1'b0, rst_n = 1'b0;
    logic [GW-1:0]  cfg;
    logic           ref_cmd_valid, ref_cmd_ready, ref_cmd_last, ref_cmd_cas, ref_cmd_ras, ref_cmd_we;
    logic [AW-1:0]  ref_cmd_a, bm_cmd_a, out_cmd_a;
    logic [BAW-1:0] ref_cmd_ba, bm_cmd_ba, out_cmd_ba;
    logic           bm_cmd_valid, bm_cmd_ready, bm_cmd_cas, bm_cmd_ras, bm_cmd_we;
    logic           out_cmd_valid, out_cmd_cas, out_cmd_ras, out_cmd_we, out_cmd_src;
    logic           ref_active, ref_proto_err;
    logic [15:0]    ref_count;

    logic [24:0]    obs;
    logic [23:0]    last_cmd;
    logic [15:0]    exp_count;
    logic           exp_err;
    int             checks, passed;

    refresh_cmd_mux #(.AW(AW), .BAW(BAW), .GW(GW)) dut (
        .sys_clk(clk), .sys_rst_n(rst_n), .ref_guard_cfg(cfg),
        .ref_cmd_valid(ref_cmd_valid), .ref_cmd_ready(ref_cmd_ready), .ref_cmd_last(ref_cmd_last),
        .ref_cmd_a(ref_cmd_a), .ref_cmd_ba(ref_cmd_ba),
        .ref_cmd_cas(ref_cmd_cas), .ref_cmd_ras(ref_cmd_ras), .ref_cmd_we(ref_cmd_we),
        .bm_cmd_valid(bm_cmd_valid), .bm_cmd_ready(bm_cmd_ready),
        .bm_cmd_a(bm_cmd_a), .bm_cmd_ba(bm_cmd_ba),
        .bm_cmd_cas(bm_cmd_cas), .bm_cmd_ras(bm_cmd_ras), .bm_cmd_we(bm_cmd_we),
        .out_cmd_valid(out_cmd_valid), .out_cmd_a(out_cmd_a), .out_cmd_ba(out_cmd_ba),
        .out_cmd_cas(out_cmd_cas), .out_cmd_ras(out_cmd_ras), .out_cmd_we(out_cmd_we),
        .out_cmd_src(out_cmd_src), .ref_active(ref_active), .ref_count(ref_count),
        .ref_proto_err(ref_proto_err)
    );

    always #5 clk = ~clk;

    // observed bus as {valid, src, a, ba, ras, cas, we}
    assign obs = {out_cmd_valid, out_cmd_src, out_cmd_a, out_cmd_ba, out_cmd_ras, out_cmd_cas, out_cmd_we};

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_bm(input logic v, input logic [AW-1:0] a, input logic [BAW-1:0] ba, input logic [2:0] s);
        bm_cmd_valid = v;
        bm_cmd_a     = a;
        bm_cmd_ba    = ba;
        {bm_cmd_ras, bm_cmd_cas, bm_cmd_we} = s;
    endtask

    task automatic drive_ref(input logic v, input logic last, input logic [AW-1:0] a, input logic [BAW-1:0] ba, input logic [2:0] s);
        ref_cmd_valid = v;
        ref_cmd_last  = last;
        ref_cmd_a     = a;
        ref_cmd_ba    = ba;
        {ref_cmd_ras, ref_cmd_cas, ref_cmd_we} = s;
    endtask

    task automatic idle;
        drive_bm(1'b0, '0, '0, 3'b000);
        drive_ref(1'b0, 1'b0, '0, '0, 3'b000);
    endtask

    // count clock edges until the grant appears; flags any bus activity or bank grant while waiting
    task automatic wait_grant(output int n, output logic bad);
        n = 0;
        bad = 1'b0;
        while (ref_cmd_ready !== 1'b1 && n < 300) begin
            tick;
            n++;
            if (out_cmd_valid !== 1'b0 || bm_cmd_ready !== 1'b0 || ref_active !== 1'b1) bad = 1'b1;
        end
    endtask

    task automatic test_reset;
        idle;
        rst_n = 1'b0;
        drive_bm(1'b1, 17'h1, 3'd1, 3'b100);
        tick;
        #1;
        checks++; if ({obs, bm_cmd_ready, ref_cmd_ready, ref_active, ref_count, ref_proto_err} !== '0)
            $display("FAIL reset_outputs: got bus=%h bm_rdy=%b ref_rdy=%b act=%b cnt=%h err=%b, all zero required",
                     obs, bm_cmd_ready, ref_cmd_ready, ref_active, ref_count, ref_proto_err); else passed++;
        idle;
        tick;
        rst_n = 1'b1;
        tick;
        #1;
        checks++; if ({bm_cmd_ready, ref_active} !== 2'b10)
            $display("FAIL reset_release: got bm_rdy=%b act=%b exp 1/0", bm_cmd_ready, ref_active); else passed++;
    endtask

    task automatic test_bm_traffic;
        logic v;
        logic [AW-1:0] a;
        logic [BAW-1:0] ba;
        logic [2:0] s;
        for (int i = 0; i < 40; i++) begin
            v  = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            a  = (i == 0) ? 17'h1A5 : AW'($urandom);
            ba = (i == 0) ? 3'd3 : BAW'($urandom);
            s  = (i == 0) ? 3'b100 : 3'($urandom);
            drive_bm(v, a, ba, s);
            #1;
            checks++; if (bm_cmd_ready !== 1'b1)
                $display("FAIL bm_ready_idle[%0d]: got %b exp 1", i, bm_cmd_ready); else passed++;
            if (v) last_cmd = {1'b0, a, ba, s};
            tick;
            checks++; if (obs !== {v, last_cmd} || ref_active !== 1'b0)
                $display("FAIL bm_issue[%0d]: got %h act=%b exp %h act=0", i, obs, ref_active, {v, last_cmd}); else passed++;
        end
        idle;
        tick;
        checks++; if (obs !== {1'b0, last_cmd})
            $display("FAIL bm_hold: got %h exp %h", obs, {1'b0, last_cmd}); else passed++;
    endtask

    task automatic test_guard(input int c);
        int n;
        logic bad;
        logic [AW-1:0] a;
        logic [BAW-1:0] ba;
        logic [2:0] s;
        cfg = GW'(c);
        a = AW'($urandom);
        ba = BAW'($urandom);
        s = 3'($urandom);
        drive_bm(1'b1, a, ba, s);
        last_cmd = {1'b0, a, ba, s};
        tick;
        checks++; if (obs !== {1'b1, last_cmd})
            $display("FAIL guard_bm_issue(cfg=%0d): got %h exp %h", c, obs, {1'b1, last_cmd}); else passed++;
        drive_bm(1'b1, AW'($urandom), BAW'($urandom), 3'b111);
        drive_ref(1'b1, 1'b0, '0, '0, 3'b000);
        #1;
        checks++; if (bm_cmd_ready !== 1'b0)
            $display("FAIL guard_bm_refused(cfg=%0d): got %b exp 0", c, bm_cmd_ready); else passed++;
        wait_grant(n, bad);
        checks++; if (n !== 1 + (c > 1 ? c : 1) || bad)
            $display("FAIL guard_grant(cfg=%0d): got %0d edges quiet=%b exp %0d edges quiet=1", c, n, !bad, 1 + (c > 1 ? c : 1)); else passed++;
        a = AW'($urandom);
        ba = BAW'($urandom);
        s = 3'($urandom_range(1, 7));
        drive_bm(1'b0, '0, '0, 3'b000);
        drive_ref(1'b1, 1'b1, a, ba, s);
        last_cmd = {1'b1, a, ba, s};
        exp_count = exp_count + 16'd1;
        tick;
        checks++; if (obs !== {1'b1, last_cmd} || ref_active !== 1'b0 || ref_count !== exp_count)
            $display("FAIL guard_last(cfg=%0d): got %h act=%b cnt=%h exp %h act=0 cnt=%h", c, obs, ref_active, ref_count, {1'b1, last_cmd}, exp_count); else passed++;
        idle;
        tick;
    endtask

    task automatic test_refresh_seq(input int trp, input int trfc);
        int n;
        logic bad;
        logic [AW-1:0] a;
        logic [BAW-1:0] ba;
        idle;
        repeat (50) tick;
        drive_ref(1'b1, 1'b0, '0, '0, 3'b000);
        wait_grant(n, bad);
        checks++; if (n !== 2 || bad)
            $display("FAIL seq_grant(trp=%0d): got %0d edges quiet=%b exp 2 quiet=1", trp, n, !bad); else passed++;
        a = AW'($urandom) | 17'h400;
        ba = BAW'($urandom);
        drive_ref(1'b1, 1'b0, a, ba, 3'b101);
        last_cmd = {1'b1, a, ba, 3'b101};
        tick;
        checks++; if (obs !== {1'b1, last_cmd})
            $display("FAIL seq_prea: got %h exp %h", obs, {1'b1, last_cmd}); else passed++;
        bad = 1'b0;
        for (int k = 1; k < trp; k++) begin
            drive_ref(1'b1, 1'b0, AW'($urandom), BAW'($urandom), 3'b000);
            tick;
            if (obs !== {1'b0, last_cmd} || ref_cmd_ready !== 1'b1) bad = 1'b1;
        end
        checks++; if (bad)
            $display("FAIL seq_trp_gap: got bus activity or lost grant, exp quiet bus holding %h", last_cmd); else passed++;
        a = AW'($urandom);
        ba = BAW'($urandom);
        drive_ref(1'b1, 1'b0, a, ba, 3'b110);
        last_cmd = {1'b1, a, ba, 3'b110};
        tick;
        checks++; if (obs !== {1'b1, last_cmd})
            $display("FAIL seq_ref: got %h exp %h", obs, {1'b1, last_cmd}); else passed++;
        bad = 1'b0;
        for (int k = 1; k < trfc; k++) begin
            drive_ref(1'b1, 1'b0, AW'($urandom), BAW'($urandom), 3'b000);
            tick;
            if (out_cmd_valid !== 1'b0 || ref_cmd_ready !== 1'b1) bad = 1'b1;
        end
        checks++; if (bad)
            $display("FAIL seq_trfc_gap: got bus activity or lost grant, exp quiet"); else passed++;
        drive_ref(1'b1, 1'b1, AW'($urandom), BAW'($urandom), 3'b000);
        exp_count = exp_count + 16'd1;
        tick;
        checks++; if ({out_cmd_valid, ref_active, ref_cmd_ready, ref_count} !== {3'b000, exp_count})
            $display("FAIL seq_done: got v=%b act=%b rdy=%b cnt=%h exp 0/0/0 cnt=%h", out_cmd_valid, ref_active, ref_cmd_ready, ref_count, exp_count); else passed++;
        idle;
        tick;
    endtask

    task automatic test_collision;
        int n;
        logic bad;
        logic [AW-1:0] ba_a, ra;
        logic [BAW-1:0] ba_b, rb;
        logic [2:0] bs, rs;
        idle;
        repeat (50) tick;
        ba_a = AW'($urandom); ba_b = BAW'($urandom); bs = 3'($urandom);
        drive_bm(1'b1, ba_a, ba_b, bs);
        drive_ref(1'b1, 1'b0, '0, '0, 3'b000);
        #1;
        checks++; if (bm_cmd_ready !== 1'b0)
            $display("FAIL coll_bm_refused: got %b exp 0", bm_cmd_ready); else passed++;
        tick;
        checks++; if ({out_cmd_valid, ref_active, ref_cmd_ready} !== 3'b010)
            $display("FAIL coll_drain: got v=%b act=%b rdy=%b exp 0/1/0", out_cmd_valid, ref_active, ref_cmd_ready); else passed++;
        wait_grant(n, bad);
        checks++; if (n !== 1 || bad)
            $display("FAIL coll_grant: got %0d edges quiet=%b exp 1 quiet=1", n, !bad); else passed++;
        ra = AW'($urandom); rb = BAW'($urandom); rs = 3'($urandom_range(1, 7));
        drive_ref(1'b1, 1'b1, ra, rb, rs);
        last_cmd = {1'b1, ra, rb, rs};
        exp_count = exp_count + 16'd1;
        tick;
        checks++; if (obs !== {1'b1, last_cmd} || ref_count !== exp_count)
            $display("FAIL coll_ref_last: got %h cnt=%h exp %h cnt=%h", obs, ref_count, {1'b1, last_cmd}, exp_count); else passed++;
        drive_ref(1'b0, 1'b0, '0, '0, 3'b000);
        #1;
        checks++; if (bm_cmd_ready !== 1'b1)
            $display("FAIL coll_bm_ready_after: got %b exp 1", bm_cmd_ready); else passed++;
        last_cmd = {1'b0, ba_a, ba_b, bs};
        tick;
        checks++; if (obs !== {1'b1, last_cmd})
            $display("FAIL coll_bm_issue: got %h exp %h", obs, {1'b1, last_cmd}); else passed++;
        idle;
        tick;
        checks++; if (obs !== {1'b0, last_cmd})
            $display("FAIL coll_no_dup: got %h exp %h", obs, {1'b0, last_cmd}); else passed++;
    endtask

    task automatic test_proto_err;
        int n;
        logic bad;
        idle;
        repeat (50) tick;
        drive_ref(1'b1, 1'b0, '0, '0, 3'b000);
        wait_grant(n, bad);
        checks++; if (n !== 2 || bad)
            $display("FAIL err_grant: got %0d edges quiet=%b exp 2 quiet=1", n, !bad); else passed++;
        drive_ref(1'b0, 1'b0, AW'($urandom), BAW'($urandom), 3'b111);
        exp_err = 1'b1;
        tick;
        checks++; if ({out_cmd_valid, ref_active, ref_proto_err, ref_count} !== {2'b00, exp_err, exp_count})
            $display("FAIL err_abort: got v=%b act=%b err=%b cnt=%h exp 0/0/1 cnt=%h", out_cmd_valid, ref_active, ref_proto_err, ref_count, exp_count); else passed++;
        drive_ref(1'b1, 1'b0, '0, '0, 3'b000);
        wait_grant(n, bad);
        drive_ref(1'b1, 1'b1, '0, '0, 3'b000);
        exp_count = exp_count + 16'd1;
        tick;
        checks++; if ({ref_proto_err, ref_active, ref_count} !== {exp_err, 1'b0, exp_count})
            $display("FAIL err_sticky: got err=%b act=%b cnt=%h exp 1/0 cnt=%h", ref_proto_err, ref_active, ref_count, exp_count); else passed++;
        idle;
        tick;
        drive_ref(1'b1, 1'b0, '0, '0, 3'b000);
        wait_grant(n, bad);
        drive_ref(1'b1, 1'b0, AW'($urandom), BAW'($urandom), 3'b010);
        tick;
        rst_n = 1'b0;
        #1;
        checks++; if ({obs, bm_cmd_ready, ref_cmd_ready, ref_active, ref_count, ref_proto_err} !== '0)
            $display("FAIL async_reset: got bus=%h bm_rdy=%b ref_rdy=%b act=%b cnt=%h err=%b, all zero required",
                     obs, bm_cmd_ready, ref_cmd_ready, ref_active, ref_count, ref_proto_err); else passed++;
        exp_count = '0;
        exp_err = 1'b0;
        last_cmd = '0;
        idle;
        tick;
        rst_n = 1'b1;
        tick;
        #1;
        checks++; if ({bm_cmd_ready, ref_active, ref_proto_err} !== 3'b100)
            $display("FAIL post_reset: got bm_rdy=%b act=%b err=%b exp 1/0/0", bm_cmd_ready, ref_active, ref_proto_err); else passed++;
    endtask

    task automatic test_wrap;
        int n;
        logic bad;
        idle;
        tick;
        force dut.ref_count = 16'hFFFF;
        #1;
        release dut.ref_count;
        exp_count = 16'hFFFF;
        #1;
        checks++; if (ref_count !== exp_count)
            $display("FAIL wrap_preload: got %h exp %h", ref_count, exp_count); else passed++;
        tick;
        drive_ref(1'b1, 1'b0, '0, '0, 3'b000);
        wait_grant(n, bad);
        drive_ref(1'b1, 1'b1, '0, '0, 3'b000);
        exp_count = exp_count + 16'd1;
        tick;
        checks++; if (ref_count !== exp_count || ref_active !== 1'b0)
            $display("FAIL wrap_count: got cnt=%h act=%b exp cnt=%h act=0", ref_count, ref_active, exp_count); else passed++;
        idle;
        tick;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        last_cmd = '0;
        exp_count = '0;
        exp_err = 1'b0;
        cfg = '0;
        idle;
        test_reset;
        test_bm_traffic;
        test_guard(12);
        test_guard(0);
        test_guard(1);
        test_guard(int'($urandom_range(2, 40)));
        test_refresh_seq(12, 97);
        repeat (2) test_refresh_seq(int'($urandom_range(2, 20)), int'($urandom_range(5, 120)));
        test_collision;
        test_proto_err;
        test_wrap;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not complete, %0d/%0d checks passed so far", passed, checks);
        $fatal(1, "timeout");
    end
endmodule
